rs_entry: RTL and testbench

//  One reservation-station slot of the out-of-order core (Tomasulo/ROB style).

---
 rtl/rs_entry_pkg.sv | 36 +++
 rtl/rs_entry_operand_slot.sv | 46 ++++
 rtl/rs_entry.sv | 67 ++++++
 tb/tb_rs_entry.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rs_entry_pkg.sv
// rs_entry_pkg: shared widths, tag constant and packet types for the reservation station
package rs_entry_pkg;
  localparam int XLEN = 32;
  localparam int ROB_IDX_LEN = 5;
  typedef logic [ROB_IDX_LEN-1:0] tag_t;
  localparam tag_t NO_TAG = '0;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
  } ID_PACKET;
  typedef struct packed {
    tag_t rs1_tag;
    tag_t rs2_tag;
    logic rs1_ready;
    logic rs2_ready;
  } MT2RS_PACKET;
  typedef struct packed {
    tag_t            reg_tag;
    logic [XLEN-1:0] reg_value;
  } CDB_PACKET;
  typedef struct packed {
    tag_t            rob_entry;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
  } ROB2RS_PACKET;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    tag_t            rob_entry;
  } IS_PACKET;
endpackage

// File: rtl/rs_entry_operand_slot.sv
// rs_entry_operand_slot: one source operand's tag/value/resolved capture with CDB snooping
module rs_entry_operand_slot
  import rs_entry_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            clear,
  input  logic            busy,
  input  tag_t            alloc_tag,
  input  logic            mt_ready,
  input  logic [XLEN-1:0] id_value,
  input  logic [XLEN-1:0] rob_value,
  input  tag_t            cdb_tag,
  input  logic [XLEN-1:0] cdb_value,
  output logic [XLEN-1:0] value,
  output logic            resolved
);
  tag_t            tag_q, tag_d;
  logic [XLEN-1:0] value_q, value_d;
  logic            resolved_q, resolved_d;
  logic            alloc_hit, wait_hit, no_tag;
  assign no_tag    = alloc_tag == NO_TAG;
  assign alloc_hit = cdb_tag != NO_TAG && cdb_tag == alloc_tag;
  assign wait_hit  = busy && !resolved_q && cdb_tag != NO_TAG && cdb_tag == tag_q;
  always_comb begin
    tag_d      = enable ? alloc_tag : tag_q;
    resolved_d = enable ? (no_tag || mt_ready || alloc_hit) :
                 clear  ? 1'b0 : (resolved_q || wait_hit);
    value_d    = enable ? (no_tag ? id_value : mt_ready ? rob_value : alloc_hit ? cdb_value : value_q) :
                 (!clear && wait_hit) ? cdb_value : value_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q      <= NO_TAG;
      value_q    <= '0;
      resolved_q <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      value_q    <= value_d;
      resolved_q <= resolved_d;
    end
  end
  assign value    = value_q;
  assign resolved = resolved_q;
endmodule

// File: rtl/rs_entry.sv
// rs_entry: one reservation-station slot holding an instruction until both operands resolve
module rs_entry
  import rs_entry_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  ID_PACKET     id_packet_in,
  input  MT2RS_PACKET  mt2rs_packet_in,
  input  CDB_PACKET    cdb_packet_in,
  input  ROB2RS_PACKET rob2rs_packet_in,
  input  logic         clear,
  input  logic         enable,
  output IS_PACKET     is_packet_out,
  output logic         busy,
  output logic         ready
);
  logic            busy_q, busy_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  tag_t            rob_entry_q, rob_entry_d;
  logic [XLEN-1:0] rs1_value, rs2_value;
  logic            rs1_resolved, rs2_resolved;
  always_comb begin
    busy_d      = enable ? 1'b1 : clear ? 1'b0 : busy_q;
    pc_d        = enable ? id_packet_in.pc : pc_q;
    inst_d      = enable ? id_packet_in.inst : inst_q;
    rob_entry_d = enable ? rob2rs_packet_in.rob_entry : rob_entry_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q      <= 1'b0;
      pc_q        <= '0;
      inst_q      <= '0;
      rob_entry_q <= NO_TAG;
    end else begin
      busy_q      <= busy_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      rob_entry_q <= rob_entry_d;
    end
  end
  rs_entry_operand_slot u_rs1 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .busy(busy_q),
    .alloc_tag(mt2rs_packet_in.rs1_tag), .mt_ready(mt2rs_packet_in.rs1_ready),
    .id_value(id_packet_in.rs1_value), .rob_value(rob2rs_packet_in.rs1_value),
    .cdb_tag(cdb_packet_in.reg_tag), .cdb_value(cdb_packet_in.reg_value),
    .value(rs1_value), .resolved(rs1_resolved)
  );
  rs_entry_operand_slot u_rs2 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .busy(busy_q),
    .alloc_tag(mt2rs_packet_in.rs2_tag), .mt_ready(mt2rs_packet_in.rs2_ready),
    .id_value(id_packet_in.rs2_value), .rob_value(rob2rs_packet_in.rs2_value),
    .cdb_tag(cdb_packet_in.reg_tag), .cdb_value(cdb_packet_in.reg_value),
    .value(rs2_value), .resolved(rs2_resolved)
  );
  assign busy  = busy_q;
  assign ready = busy_q && rs1_resolved && rs2_resolved;
  always_comb begin
    is_packet_out           = '0;
    is_packet_out.valid     = ready;
    is_packet_out.pc        = pc_q;
    is_packet_out.inst      = inst_q;
    is_packet_out.rs1_value = rs1_value;
    is_packet_out.rs2_value = rs2_value;
    is_packet_out.rob_entry = rob_entry_q;
  end
endmodule

// File: tb/tb_rs_entry.sv
// tb_rs_entry: table-driven scoreboard bench for the reservation-station slot
module tb_rs_entry;
  import rs_entry_pkg::*;
  logic         clock, reset, clear, enable, busy, ready;
  ID_PACKET     id_in;
  MT2RS_PACKET  mt_in;
  CDB_PACKET    cdb_in;
  ROB2RS_PACKET rob_in;
  IS_PACKET     is_out;
  int total = 0, passed = 0;

  rs_entry dut (
    .clock(clock), .reset(reset), .id_packet_in(id_in), .mt2rs_packet_in(mt_in),
    .cdb_packet_in(cdb_in), .rob2rs_packet_in(rob_in), .clear(clear), .enable(enable),
    .is_packet_out(is_out), .busy(busy), .ready(ready)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic r, e, c;
    logic [4:0] t1, t2;
    logic m1, m2;
    logic [31:0] iv1, iv2, rv1, rv2;
    logic [4:0] ct;
    logic [31:0] cv;
    logic xb, xr, chk;
    logic [31:0] x1, x2;
  } vec_t;
  typedef struct {
    logic xb, xr, chk;
    logic [31:0] x1, x2;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic r, logic e, logic c, logic [4:0] t1, logic [4:0] t2,
                              logic m1, logic m2, logic [31:0] iv1, logic [31:0] iv2,
                              logic [31:0] rv1, logic [31:0] rv2, logic [4:0] ct, logic [31:0] cv,
                              logic xb, logic xr, logic chk, logic [31:0] x1, logic [31:0] x2);
    vec_t v;
    v.r = r; v.e = e; v.c = c; v.t1 = t1; v.t2 = t2; v.m1 = m1; v.m2 = m2;
    v.iv1 = iv1; v.iv2 = iv2; v.rv1 = rv1; v.rv2 = rv2; v.ct = ct; v.cv = cv;
    v.xb = xb; v.xr = xr; v.chk = chk; v.x1 = x1; v.x2 = x2;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic idle_inputs();
    reset = 0; enable = 0; clear = 0;
    id_in = '0; mt_in = '0; cdb_in = '0; rob_in = '0;
  endtask

  task automatic apply(int i, vec_t v);
    exp_t e;
    @(negedge clock);
    reset = v.r; enable = v.e; clear = v.c;
    id_in = '0; id_in.rs1_value = v.iv1; id_in.rs2_value = v.iv2;
    mt_in.rs1_tag = v.t1; mt_in.rs2_tag = v.t2; mt_in.rs1_ready = v.m1; mt_in.rs2_ready = v.m2;
    rob_in.rob_entry = 5'(i); rob_in.rs1_value = v.rv1; rob_in.rs2_value = v.rv2;
    cdb_in.reg_tag = v.ct; cdb_in.reg_value = v.cv;
    sb.push_back('{v.xb, v.xr, v.chk, v.x1, v.x2});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check($sformatf("v%0d busy", i), 32'(busy), 32'(e.xb));
    check($sformatf("v%0d ready", i), 32'(ready), 32'(e.xr));
    check($sformatf("v%0d valid", i), 32'(is_out.valid), 32'(e.xr));
    if (e.chk) begin
      check($sformatf("v%0d rs1", i), is_out.rs1_value, e.x1);
      check($sformatf("v%0d rs2", i), is_out.rs2_value, e.x2);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    // reset
    vecs.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,1,0,0));
    // tags 0/0 take regfile values; hold; clear
    vecs.push_back(mk(0,1,0, 0,0,0,0, 1,1,7,8, 0,0, 1,1,1,1,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 1,1,1,1,1));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0));
    // ROB-ready operands come from the ROB
    vecs.push_back(mk(0,1,0, 1,1,1,1, 5,6,0,0, 0,0, 1,1,1,0,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0));
    // both waiting on tag 1, enable held twice, one CDB resolves both
    vecs.push_back(mk(0,1,0, 1,1,0,0, 5,6,9,9, 0,0, 1,0,0,0,0));
    vecs.push_back(mk(0,1,0, 1,1,0,0, 5,6,9,9, 0,0, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 1,1, 1,1,1,1,1));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0));
    // rs1 waits on 2, rs2 ROB-ready; broadcast of 3 must not disturb resolved rs2
    vecs.push_back(mk(0,1,0, 2,3,0,1, 5,6,0,33, 0,0, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 3,77, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 2,10, 1,1,1,10,33));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0));
    // tags 3/4 resolved in separate cycles
    vecs.push_back(mk(0,1,0, 3,4,0,0, 0,0,0,0, 0,0, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 4,44, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 3,30, 1,1,1,30,44));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0));
    // same-cycle bypass at allocation
    vecs.push_back(mk(0,1,0, 5,6,0,0, 0,0,0,0, 5,55, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 6,66, 1,1,1,55,66));
    // enable+clear loads; overwrite while busy; reset mid-wait; CDB while idle
    vecs.push_back(mk(0,1,1, 0,0,0,0, 3,4,0,0, 0,0, 1,1,1,3,4));
    vecs.push_back(mk(0,1,0, 7,7,0,0, 0,0,0,0, 0,0, 1,0,0,0,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 7,77, 0,0,0,0,0));
    // ROB-ready beats CDB match; CDB match beats waiting
    vecs.push_back(mk(0,1,0, 8,8,1,0, 0,0,80,81, 8,88, 1,1,1,80,88));
    // clear while waiting, then the awaited tag arrives
    vecs.push_back(mk(0,1,0, 9,9,0,0, 0,0,0,0, 0,0, 1,0,0,0,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 9,90, 0,0,0,0,0));
    foreach (vecs[i]) apply(i, vecs[i]);

    // packet fields and rob_entry carried through
    @(negedge clock);
    idle_inputs();
    enable = 1;
    id_in.pc = 32'h100; id_in.inst = 32'hdeadbeef; id_in.rs1_value = 32'h11; id_in.rs2_value = 32'h22;
    rob_in.rob_entry = 5'd13;
    @(posedge clock); #1;
    check("pkt valid", 32'(is_out.valid), 32'd1);
    check("pkt pc", is_out.pc, 32'h100);
    check("pkt inst", is_out.inst, 32'hdeadbeef);
    check("pkt rob_entry", 32'(is_out.rob_entry), 32'd13);
    // held data unaffected by later idle inputs
    @(negedge clock);
    idle_inputs();
    id_in.pc = 32'h999; rob_in.rob_entry = 5'd2;
    @(posedge clock); #1;
    check("hold pc", is_out.pc, 32'h100);
    check("hold rob_entry", 32'(is_out.rob_entry), 32'd13);
    check("hold rs1", is_out.rs1_value, 32'h11);
    @(negedge clock);
    idle_inputs();
    clear = 1;
    @(posedge clock); #1;
    check("clr valid", 32'(is_out.valid), 32'd0);
    check("clr busy", 32'(busy), 32'd0);
    @(negedge clock);
    idle_inputs();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
